// File: rtl/dp_sequencer_if.sv
// Bundle between the host/instruction side, dp_sequencer and the register/ALU datapath.
// The slave modport is the sequencer's view. The master modport is the view of the host and datapath.
interface dp_sequencer_if #(
    parameter int BIT_WIDTH = 1
);
    logic                 start;
    logic                 chain;
    logic                 op;
    logic [BIT_WIDTH-1:0] operand_a;
    logic [BIT_WIDTH-1:0] operand_b;
    logic                 busy;
    logic                 done;
    logic [BIT_WIDTH-1:0] result;
    logic                 carry;
    logic [BIT_WIDTH-1:0] dp_data_in;
    logic [1:0]           dp_reg_addr;
    logic                 dp_reg_sel;
    logic                 dp_op_sel;
    logic [BIT_WIDTH-1:0] dp_out;
    logic                 dp_cout;

    modport slave (
        input  start, chain, op, operand_a, operand_b, dp_out, dp_cout,
        output busy, done, result, carry, dp_data_in, dp_reg_addr, dp_reg_sel, dp_op_sel
    );

    modport master (
        output start, chain, op, operand_a, operand_b, dp_out, dp_cout,
        input  busy, done, result, carry, dp_data_in, dp_reg_addr, dp_reg_sel, dp_op_sel
    );
endinterface

// File: rtl/dp_sequencer.sv
// Multi-cycle controller for the two-operand register/ALU datapath.
// It runs load A, load B, execute and transfer, then strobes done with the result and carry.
module dp_sequencer #(
    parameter int BIT_WIDTH = 1
) (
    input  logic           clk,
    input  logic           rst,
    dp_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_EXEC,
        S_XFER,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [BIT_WIDTH-1:0] r_a;
    logic [BIT_WIDTH-1:0] r_b;
    logic                 r_op;
    logic                 r_carry;

    logic [BIT_WIDTH-1:0] w_data_in;
    logic [1:0]           w_reg_addr;
    logic                 w_reg_sel;
    logic                 w_op_sel;
    logic                 w_busy;
    logic                 w_done;

    // chain is used only in the IDLE cycle that accepts the request, so it is not stored.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 1'b0;
            r_carry <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start) begin
                r_a  <= bus.operand_a;
                r_b  <= bus.operand_b;
                r_op <= bus.op;
            end
            // Capture dp_cout on this edge. It still holds the carry from the EXEC edge here.
            if (r_state == S_XFER)
                r_carry <= bus.dp_cout;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_data_in  = '0;
        w_reg_addr = 2'd3;
        w_reg_sel  = 1'b0;
        w_op_sel   = 1'b0;
        w_busy     = 1'b1;
        w_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start)
                    w_next = bus.chain ? S_LOAD_B : S_LOAD_A;
            end
            S_LOAD_A: begin
                w_reg_addr = 2'd0;
                w_reg_sel  = 1'b1;
                w_data_in  = r_a;
                w_next     = S_LOAD_B;
            end
            S_LOAD_B: begin
                w_reg_addr = 2'd1;
                w_reg_sel  = 1'b1;
                w_data_in  = r_b;
                w_next     = S_EXEC;
            end
            S_EXEC: begin
                w_reg_addr = 2'd0;
                w_op_sel   = r_op;
                w_next     = S_XFER;
            end
            S_XFER: begin
                w_reg_addr = 2'd2;
                w_op_sel   = r_op;
                w_next     = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.result      = bus.dp_out;
    assign bus.carry       = r_carry;
    assign bus.dp_data_in  = w_data_in;
    assign bus.dp_reg_addr = w_reg_addr;
    assign bus.dp_reg_sel  = w_reg_sel;
    assign bus.dp_op_sel   = w_op_sel;
endmodule

// File: tb/tb_dp_sequencer.sv
// Directed bench for dp_sequencer. It includes a behavioural model of the register/ALU datapath.
// A scoreboard queue holds the expected {carry, result} for each accepted request.
module tb_dp_sequencer;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dp_sequencer_if #(.BIT_WIDTH(W)) bus ();

    dp_sequencer #(.BIT_WIDTH(W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Datapath model. Opcode 0 adds and opcode 1 subtracts. The carry register is reloaded on every edge.
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_o = '0;
    logic         m_c = 1'b0;
    logic [W:0]   w_alu;

    always_comb w_alu = bus.dp_op_sel ? ({1'b0, m_a} - {1'b0, m_b}) : ({1'b0, m_a} + {1'b0, m_b});

    always @(posedge clk) begin
        m_c <= w_alu[W];
        case (bus.dp_reg_addr)
            2'd0:    m_a <= bus.dp_reg_sel ? bus.dp_data_in : w_alu[W-1:0];
            2'd1:    m_b <= bus.dp_reg_sel ? bus.dp_data_in : w_alu[W-1:0];
            2'd2:    m_o <= m_a;
            default: ;
        endcase
    end

    assign bus.dp_out  = m_o;
    assign bus.dp_cout = m_c;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [W:0]  sb_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_addr"}, 32'(bus.dp_reg_addr), 32'd3);
    endtask

    // Issue one request and walk its fixed-latency cycles. If inject is set, also pulse a stray start in cycle 2.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic op, input logic ch, input logic inject,
                          input logic [W-1:0] exp_r, input logic exp_c);
        int unsigned n;
        logic [1:0]  seq[5];
        logic [W:0]  exp;
        n = ch ? 4 : 5;
        if (ch) seq = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd3};
        else    seq = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd3};
        bus.operand_a = a;
        bus.operand_b = b;
        bus.op        = op;
        bus.chain     = ch;
        bus.start     = 1'b1;
        sb_q.push_back({exp_c, exp_r});
        tick();
        // Scramble the inputs after the request is accepted, so that only the latched values can appear on the datapath.
        bus.start     = 1'b0;
        bus.operand_a = ~a;
        bus.operand_b = ~b;
        bus.op        = ~op;
        bus.chain     = 1'b0;
        for (int unsigned k = 1; k <= n; k++) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_addr"}, 32'(bus.dp_reg_addr), 32'(seq[k-1]));
            chk({tag, "_done"}, 32'(bus.done), 32'(k == n));
            if (!ch && k == 1) begin
                chk({tag, "_ldA_data"}, 32'(bus.dp_data_in), 32'(a));
                chk({tag, "_ldA_sel"}, 32'(bus.dp_reg_sel), 32'd1);
            end
            if (k == (ch ? 1 : 2)) begin
                chk({tag, "_ldB_data"}, 32'(bus.dp_data_in), 32'(b));
                chk({tag, "_ldB_sel"}, 32'(bus.dp_reg_sel), 32'd1);
            end
            if (k == n - 2 || k == n - 1) begin
                chk({tag, "_opsel"}, 32'(bus.dp_op_sel), 32'(op));
                chk({tag, "_data0"}, 32'(bus.dp_data_in), 32'd0);
            end
            if (k == n) begin
                chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    exp = sb_q.pop_front();
                    chk({tag, "_result"}, 32'(bus.result), 32'(exp[W-1:0]));
                    chk({tag, "_carry"}, 32'(bus.carry), 32'(exp[W]));
                end
            end
            if (inject && k == 2) begin
                bus.start     = 1'b1;
                bus.operand_a = 4'hF;
            end
            if (inject && k == 3) bus.start = 1'b0;
            tick();
        end
        idle_checks({tag, "_after"});
    endtask

    initial begin
        bus.start     = 1'b1;
        bus.chain     = 1'b0;
        bus.op        = 1'b0;
        bus.operand_a = 4'd5;
        bus.operand_b = 4'd5;

        // Reset held for two edges while start is high.
        rst = 1'b1;
        for (int unsigned i = 0; i < 2; i++) begin
            tick();
            idle_checks("rst");
            chk("rst_carry", 32'(bus.carry), 32'd0);
            chk("rst_sel", 32'(bus.dp_reg_sel), 32'd0);
            chk("rst_opsel", 32'(bus.dp_op_sel), 32'd0);
            chk("rst_data", 32'(bus.dp_data_in), 32'd0);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        tick();
        idle_checks("idle");

        run_op("add", 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 4'd7, 1'b0);
        run_op("chain", 4'd0, 4'd2, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0);
        run_op("ovf", 4'd9, 4'd8, 1'b0, 1'b0, 1'b0, 4'd1, 1'b1);
        // The carry must hold even though the datapath carry register now reads 1+8 with no carry.
        for (int unsigned i = 0; i < 3; i++) begin
            chk("ovf_carry_hold", 32'(bus.carry), 32'd1);
            chk("ovf_result_hold", 32'(bus.result), 32'd1);
            tick();
        end
        run_op("sub", 4'd3, 4'd4, 1'b1, 1'b0, 1'b0, 4'hF, 1'b1);
        run_op("busy_start", 4'd5, 4'd6, 1'b0, 1'b0, 1'b1, 4'hB, 1'b0);
        for (int unsigned i = 0; i < 7; i++) begin
            idle_checks("no_requeue");
            chk("no_requeue_result", 32'(bus.result), 32'hB);
            tick();
        end

        // Reset during EXEC. The aborted request was never pushed, so the scoreboard expects no done for it.
        bus.operand_a = 4'd2;
        bus.operand_b = 4'd5;
        bus.op        = 1'b0;
        bus.chain     = 1'b0;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("midrst_exec_addr", 32'(bus.dp_reg_addr), 32'd0);
        chk("midrst_exec_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_checks("midrst");
        chk("midrst_carry", 32'(bus.carry), 32'd0);
        for (int unsigned i = 0; i < 5; i++) begin
            tick();
            idle_checks("midrst_quiet");
        end
        run_op("fresh", 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dp_sequencer.md
# dp_sequencer

Multi-cycle controller for the two-operand register/ALU datapath. Accepts one operation request (operands plus op select) and drives the datapath control lines: load A, load B, execute, transfer to output register. It then presents the result and carry with a one-cycle done strobe. It sits between the instruction/host side and the datapath and is the only block that drives the datapath control inputs.

## Interface
- BIT_WIDTH, default 1, datapath word width; must equal the datapath's BIT_WIDTH.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request strobe; sampled only in IDLE.
- chain  in  1  sampled with start; 1 = reuse current register A contents (previous result) as operand A and skip the A load.
- op  in  1  operation select, forwarded to dp_op_sel during EXEC.
- operand_a  in  BIT_WIDTH  operand A; sampled with start.
- operand_b  in  BIT_WIDTH  operand B; sampled with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle strobe in DONE.
- result  out  BIT_WIDTH  equals dp_out; valid while done=1 and held until the next XFER.
- carry  out  1  registered carry of the last EXEC.
- dp_data_in  out  BIT_WIDTH  to datapath data input.
- dp_reg_addr  out  2  register write select: 0=A, 1=B, 2=O (O loads from A), 3=none.
- dp_reg_sel  out  1  1 = register input from dp_data_in, 0 = from ALU.
- dp_op_sel  out  1  ALU operation.
- dp_out  in  BIT_WIDTH  datapath output register O.
- dp_cout  in  1  datapath registered carry (reloaded every cycle).

## Operation
- States: IDLE, LOAD_A, LOAD_B, EXEC, XFER, DONE. Encoding is free; the state must be registered.
- IDLE:
  - reg_addr=3, reg_sel=0, op_sel=0, data_in=0.
  - On start=1, latch operand_a, operand_b, op and chain into internal registers.
  - Go to LOAD_B if chain=1, else LOAD_A.
- LOAD_A: reg_addr=0, reg_sel=1, data_in=latched A. Next state LOAD_B.
- LOAD_B: reg_addr=1, reg_sel=1, data_in=latched B. Next state EXEC.
- EXEC: reg_addr=0, reg_sel=0, op_sel=latched op; the ALU result is written into A. Next state XFER.
- XFER:
  - reg_addr=2, reg_sel=0, op_sel=latched op.
  - Capture dp_cout into carry at this edge. dp_cout here is the carry produced by the EXEC edge; the datapath carry register is overwritten on later cycles, so it must be captured at exactly this edge.
  - Next state DONE.
- DONE: reg_addr=3, done=1. Next state IDLE.
- Datapath outputs are decoded from state only (Moore). data_in=0 outside the LOAD states. op_sel=0 outside EXEC/XFER.
- start while busy is ignored and is not queued. Operand/op changes while busy have no effect.
- chain=1 is legal at any time. If no operation has run since reset, operand A is whatever register A holds; the controller does not guard this case.

## Timing
- Reset: state=IDLE, busy=0, done=0, carry=0, dp_reg_addr=3, dp_reg_sel=0, dp_op_sel=0, dp_data_in=0, latched operands=0.
- Reset asserted in any state takes effect at the next edge: IDLE, no done pulse, in-flight request discarded. Datapath register contents are not cleared.
- Latency, counting from the edge that samples start (edge 0):
  - Normal: done high in cycle 5 (LOAD_A c1, LOAD_B c2, EXEC c3, XFER c4, DONE c5).
  - Chain: done high in cycle 4.
- Back-to-back: start may be held high. A new request is accepted on the first IDLE cycle, one cycle after DONE. Minimum issue interval is 6 cycles (normal) or 5 cycles (chain).
- result equals dp_out from DONE onward. carry is valid from DONE onward and holds until the next XFER edge.
- busy rises the cycle after start is sampled and falls the cycle after DONE.

## Test plan
- Reset then idle: assert rst 2 cycles with start=1 → busy=0, done=0, carry=0, dp_reg_addr=3 throughout.
- Single add, BIT_WIDTH=4:
  - Stimulus: start with A=3, B=4, op=0.
  - dp_reg_addr sequence is 0,1,0,2,3.
  - done in cycle 5 with result=7, carry=0.
  - busy high for cycles 1–5 only.
- Add with overflow, BIT_WIDTH=4: A=9, B=8, op=0 → result=1, carry=1. carry stays 1 through the following idle cycles even though dp_cout changes.
- Chain: after the 3+4 run, start with chain=1, B=2, op=0 → no LOAD_A cycle (reg_addr sequence 1,0,2,3); done in cycle 4; result=9.
- Start while busy: pulse start with A=15 in cycle 2 of a running op → ignored; original result unchanged; exactly one done pulse.
- Reset mid-operation: assert rst during EXEC → next cycle IDLE, reg_addr=3, no done. A fresh request afterwards (A=1, B=1) yields result=2.
